// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: hazard detection and operand forwarding for the ID stage.
// Tracks one destination record per in-flight stage after ID (1=EX, 2=MEM, ...),
// picks the youngest writer of each source operand as its forward source, and
// stalls the front end while that youngest writer is a load whose result is not
// yet forwardable.
module pipe_hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16,
  parameter int FW         = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_wreg,
  input  logic             id_load,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ext_stall,
  output logic [FW-1:0]    fwda,
  output logic [FW-1:0]    fwdb,
  output logic             wpcir,
  output logic [CNT_W-1:0] stall_cnt
);

  // Parameter legality: an illegal configuration must not elaborate.
  if (STAGES < 2 || STAGES > 7) begin : g_chk_stages
    $fatal(1, "pipe_hazard_scoreboard: STAGES must be in 2..7");
  end
  if (LOAD_AVAIL < 1 || LOAD_AVAIL > STAGES) begin : g_chk_load_avail
    $fatal(1, "pipe_hazard_scoreboard: LOAD_AVAIL must be in 1..STAGES");
  end
  if ((1 << FW) <= STAGES) begin : g_chk_fw
    $fatal(1, "pipe_hazard_scoreboard: FW too narrow to encode every stage");
  end

  // In-flight records, index k = stage k after ID.
  logic [STAGES:1]            r_v;
  logic [STAGES:1]            r_wreg;
  logic [STAGES:1]            r_load;
  logic [STAGES:1][REG_W-1:0] r_rd;
  logic [CNT_W-1:0]           r_cnt;

  logic [FW-1:0] w_fwda;
  logic [FW-1:0] w_fwdb;
  logic          w_rs_haz;
  logic          w_rt_haz;
  logic          w_hazard;
  logic          w_insert;

  // Youngest-writer search per operand; the youngest match alone decides both
  // the forward source and whether that source is still an unfinished load.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_fwda   = '0;
    w_fwdb   = '0;
    w_rs_haz = 1'b0;
    w_rt_haz = 1'b0;
    // Walk oldest to youngest so the last hit (smallest k) wins.
    for (int k = STAGES; k >= 1; k--) begin
      if (r_v[k] && r_wreg[k] && (r_rd[k] != '0) && (r_rd[k] == id_rs)) begin
        w_fwda   = FW'(k);
        w_rs_haz = r_load[k] && (k < LOAD_AVAIL);
      end
      if (r_v[k] && r_wreg[k] && (r_rd[k] != '0) && (r_rd[k] == id_rt)) begin
        w_fwdb   = FW'(k);
        w_rt_haz = r_load[k] && (k < LOAD_AVAIL);
      end
    end
    if (!id_use_rs) begin
      w_fwda   = '0;
      w_rs_haz = 1'b0;
    end
    if (!id_use_rt) begin
      w_fwdb   = '0;
      w_rt_haz = 1'b0;
    end
  end

  assign w_hazard  = id_valid & (w_rs_haz | w_rt_haz);
  assign w_insert  = id_valid & ~w_hazard;
  assign fwda      = w_fwda;
  assign fwdb      = w_fwdb;
  assign wpcir     = ~w_hazard & ~ext_stall;
  assign stall_cnt = r_cnt;

  // Valid bits and stall counter: freeze on ext_stall, bubble on hazard, else shift in ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v   <= '0;
      r_cnt <= '0;
    end else if (!ext_stall) begin
      for (int k = STAGES; k >= 2; k--) begin
        r_v[k] <= r_v[k-1];
      end
      r_v[1] <= w_insert;
      if (w_hazard && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Record payload shifts alongside the valid bits.
  // NOTE: the payload has no reset; every use of it is gated by r_v, which is reset.
  always_ff @(posedge clock) begin
    if (!ext_stall) begin
      for (int k = STAGES; k >= 2; k--) begin
        r_wreg[k] <= r_wreg[k-1];
        r_load[k] <= r_load[k-1];
        r_rd[k]   <= r_rd[k-1];
      end
      r_wreg[1] <= id_wreg & w_insert;
      r_load[1] <= id_load & w_insert;
      r_rd[1]   <= id_rd;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: three configurations share one
// stimulus stream (default, STAGES=4/LOAD_AVAIL=3, CNT_W=2); each scenario
// checks the instance it is about.
module tb_pipe_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_wreg, id_load, id_use_rs, id_use_rt, ext_stall;
  logic [4:0] id_rd, id_rs, id_rt;

  logic [2:0]  fwda_d, fwdb_d, fwda_4, fwdb_4, fwda_c, fwdb_c;
  logic        wpcir_d, wpcir_4, wpcir_c;
  logic [15:0] cnt_d, cnt_4;
  logic [1:0]  cnt_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipe_hazard_scoreboard u_dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_wreg(id_wreg),
    .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ext_stall(ext_stall),
    .fwda(fwda_d), .fwdb(fwdb_d), .wpcir(wpcir_d), .stall_cnt(cnt_d)
  );

  pipe_hazard_scoreboard #(.STAGES(4), .LOAD_AVAIL(3)) u_dut4 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_wreg(id_wreg),
    .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ext_stall(ext_stall),
    .fwda(fwda_4), .fwdb(fwdb_4), .wpcir(wpcir_4), .stall_cnt(cnt_4)
  );

  pipe_hazard_scoreboard #(.CNT_W(2)) u_dutc (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_wreg(id_wreg),
    .id_load(id_load), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ext_stall(ext_stall),
    .fwda(fwda_c), .fwdb(fwdb_c), .wpcir(wpcir_c), .stall_cnt(cnt_c)
  );

  // Wait for the next falling edge, apply one ID instruction, settle 1ns.
  task automatic drive(input logic v, input logic w, input logic l,
                       input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt);
    @(negedge clock);
    id_valid = v; id_wreg = w; id_load = l; id_rd = rd;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    id_valid = 1'b0; id_wreg = 1'b0; id_load = 1'b0; id_rd = '0;
    id_rs = 5'd1; id_rt = 5'd2; id_use_rs = 1'b1; id_use_rt = 1'b1;
    ext_stall = 1'b0; reset = 1'b1;
    #1;
    n_vec++;
    if (fwda_d !== 3'd0 || fwdb_d !== 3'd0 || wpcir_d !== 1'b1 || cnt_d !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: fwda=%0d fwdb=%0d wpcir=%0b cnt=%0d, want 0 0 1 0",
               fwda_d, fwdb_d, wpcir_d, cnt_d);
    end
    ext_stall = 1'b1;
    #1;
    n_vec++;
    if (wpcir_d !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ext_stall: wpcir=%0b, want 0", wpcir_d);
    end
    ext_stall = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_alu_back_to_back();
    do_reset();
    drive(1, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1);      // add r3
    drive(1, 1, 0, 5'd4, 5'd3, 5'd3, 1, 1);      // add r4,r3,r3
    n_vec++;
    if (fwda_d !== 3'd1 || fwdb_d !== 3'd1 || wpcir_d !== 1'b1) begin
      n_err++;
      $display("FAIL alu_adjacent: fwda=%0d fwdb=%0d wpcir=%0b, want 1 1 1", fwda_d, fwdb_d, wpcir_d);
    end
    drive(1, 1, 0, 5'd6, 5'd3, 5'd4, 1, 1);      // r3 now in MEM, r4 in EX
    n_vec++;
    if (fwda_d !== 3'd2 || fwdb_d !== 3'd1 || wpcir_d !== 1'b1) begin
      n_err++;
      $display("FAIL alu_distance2: fwda=%0d fwdb=%0d wpcir=%0b, want 2 1 1", fwda_d, fwdb_d, wpcir_d);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0);      // lw r5
    drive(1, 1, 0, 5'd8, 5'd5, 5'd1, 1, 1);      // user of r5
    n_vec++;
    if (wpcir_d !== 1'b0 || cnt_d !== 16'd0) begin
      n_err++;
      $display("FAIL load_use_stall: wpcir=%0b cnt=%0d, want 0 0", wpcir_d, cnt_d);
    end
    drive(1, 1, 0, 5'd8, 5'd5, 5'd1, 1, 1);      // held instruction re-evaluates
    n_vec++;
    if (wpcir_d !== 1'b1 || fwda_d !== 3'd2 || cnt_d !== 16'd1) begin
      n_err++;
      $display("FAIL load_use_release: wpcir=%0b fwda=%0d cnt=%0d, want 1 2 1", wpcir_d, fwda_d, cnt_d);
    end
  endtask

  task automatic test_load_use_deep();
    logic       exp_w [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0] exp_f [3] = '{3'd1, 3'd2, 3'd3};
    logic [15:0] exp_c [3] = '{16'd0, 16'd1, 16'd2};
    do_reset();
    drive(1, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 5'd8, 5'd5, 5'd1, 1, 1);
      n_vec++;
      if (wpcir_4 !== exp_w[i] || fwda_4 !== exp_f[i] || cnt_4 !== exp_c[i]) begin
        n_err++;
        $display("FAIL deep_load_use[%0d]: wpcir=%0b fwda=%0d cnt=%0d, want %0b %0d %0d",
                 i, wpcir_4, fwda_4, cnt_4, exp_w[i], exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_youngest_wins();
    do_reset();
    drive(1, 1, 0, 5'd7, 5'd0, 5'd0, 0, 0);      // addi r7
    drive(1, 1, 0, 5'd7, 5'd0, 5'd0, 0, 0);      // add r7
    drive(1, 1, 0, 5'd9, 5'd7, 5'd0, 1, 0);
    n_vec++;
    if (fwda_d !== 3'd1 || wpcir_d !== 1'b1) begin
      n_err++;
      $display("FAIL youngest_alu: fwda=%0d wpcir=%0b, want 1 1", fwda_d, wpcir_d);
    end
    do_reset();
    drive(1, 1, 0, 5'd7, 5'd0, 5'd0, 0, 0);      // ALU r7 -> stage 2
    drive(1, 1, 1, 5'd7, 5'd0, 5'd0, 0, 0);      // lw r7  -> stage 1
    drive(1, 1, 0, 5'd9, 5'd7, 5'd0, 1, 0);
    n_vec++;
    if (fwda_d !== 3'd1 || wpcir_d !== 1'b0) begin
      n_err++;
      $display("FAIL youngest_load: fwda=%0d wpcir=%0b, want 1 0", fwda_d, wpcir_d);
    end
  endtask

  task automatic test_r0_and_flags();
    do_reset();
    drive(1, 1, 1, 5'd0, 5'd0, 5'd0, 0, 0);      // lw r0
    drive(1, 1, 1, 5'd9, 5'd0, 5'd0, 0, 0);      // lw r9
    drive(1, 1, 0, 5'd10, 5'd0, 5'd9, 1, 0);     // reads r0, rt=r9 unused
    n_vec++;
    if (fwda_d !== 3'd0 || fwdb_d !== 3'd0 || wpcir_d !== 1'b1) begin
      n_err++;
      $display("FAIL r0_and_use_flags: fwda=%0d fwdb=%0d wpcir=%0b, want 0 0 1", fwda_d, fwdb_d, wpcir_d);
    end
  endtask

  task automatic test_ext_stall();
    do_reset();
    drive(1, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
    drive(1, 1, 0, 5'd8, 5'd0, 5'd5, 0, 1);      // rt user, hazard this cycle
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 5'd8, 5'd0, 5'd5, 0, 1);
      n_vec++;
      if (fwdb_d !== 3'd1 || wpcir_d !== 1'b0 || cnt_d !== 16'd0) begin
        n_err++;
        $display("FAIL ext_stall_frozen[%0d]: fwdb=%0d wpcir=%0b cnt=%0d, want 1 0 0",
                 i, fwdb_d, wpcir_d, cnt_d);
      end
    end
    @(negedge clock);
    ext_stall = 1'b0;                             // hazard still pending now
    #1;
    n_vec++;
    if (wpcir_d !== 1'b0 || cnt_d !== 16'd0) begin
      n_err++;
      $display("FAIL ext_stall_resume: wpcir=%0b cnt=%0d, want 0 0", wpcir_d, cnt_d);
    end
    drive(1, 1, 0, 5'd8, 5'd0, 5'd5, 0, 1);
    n_vec++;
    if (fwdb_d !== 3'd2 || wpcir_d !== 1'b1 || cnt_d !== 16'd1) begin
      n_err++;
      $display("FAIL ext_stall_release: fwdb=%0d wpcir=%0b cnt=%0d, want 2 1 1", fwdb_d, wpcir_d, cnt_d);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
    drive(1, 1, 0, 5'd8, 5'd5, 5'd0, 1, 0);
    n_vec++;
    if (wpcir_d !== 1'b0) begin
      n_err++;
      $display("FAIL mid_stall_pre: wpcir=%0b, want 0", wpcir_d);
    end
    #1 reset = 1'b1;                               // asynchronous, between edges
    #1;
    n_vec++;
    if (wpcir_d !== 1'b1 || fwda_d !== 3'd0 || cnt_d !== 16'd0) begin
      n_err++;
      $display("FAIL mid_stall_reset: wpcir=%0b fwda=%0d cnt=%0d, want 1 0 0", wpcir_d, fwda_d, cnt_d);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0);    // lw r5
      drive(1, 0, 0, 5'd6, 5'd5, 5'd0, 1, 0);    // user stalls one cycle
      drive(1, 0, 0, 5'd6, 5'd5, 5'd0, 1, 0);    // released
      n_vec++;
      if (cnt_c !== ((i > 3) ? 2'd3 : 2'(i)) || cnt_d !== 16'(i)) begin
        n_err++;
        $display("FAIL saturation[%0d]: cnt2=%0d cnt16=%0d, want %0d %0d",
                 i, cnt_c, cnt_d, (i > 3) ? 3 : i, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_load_use_deep();
    test_youngest_wins();
    test_r0_and_flags();
    test_ext_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
